// File: rtl/message_receiver.sv
// Frame receiver for a destuffed CAN-style bit stream.
// Consumes one bit per updated_sample strobe, tracks the frame fields,
// checks the CRC-15 and the fixed-form fields, drives the ACK request, and
// publishes a completed frame only after a clean end of frame.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   updated_sample        one-cycle strobe qualifying rx / error inputs
//   rx                    destuffed bit, 1 = dominant
//   stuff_error/bit_error error reports from destuffer / local transmitter
//   msg_id, extended, rtr, msg_bytes, msg   last valid frame
//   msg_fresh             pulse when the outputs above update
//   fire_an_ack           request a dominant ACK during the ACK slot
//   bus_idle, stuff_bypass, running_start   bus status
//   FORM_ERROR, OVERLOAD_ERROR, transmission_error   error pulses
module message_receiver (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        updated_sample,
  input  logic        rx,
  input  logic        stuff_error,
  input  logic        bit_error,
  output logic [28:0] msg_id,
  output logic        extended,
  output logic        rtr,
  output logic [3:0]  msg_bytes,
  output logic [63:0] msg,
  output logic        msg_fresh,
  output logic        fire_an_ack,
  output logic        bus_idle,
  output logic        stuff_bypass,
  output logic        running_start,
  output logic        FORM_ERROR,
  output logic        OVERLOAD_ERROR,
  output logic        transmission_error
);

  localparam int unsigned BID_W  = 11;
  localparam int unsigned EID_W  = 18;
  localparam int unsigned CRC_W  = 15;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = 7;
  localparam logic [CRC_W-1:0] CRC_POLY = 15'h4599;

  typedef enum logic [3:0] {
    IDLE, ARB_BASE, SRR_IDE, ARB_EXT, CTRL, DATA, CRC, CRC_DELIM,
    ACK, ACK_DELIM, EOF, INTERMISSION, WAIT_IDLE
  } state_t;

  state_t state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [CRC_W-1:0]  crc, crc_n, crc_rx, crc_rx_n;
  logic [BID_W-1:0]  base_id, base_id_n;
  logic [EID_W-1:0]  ext_id, ext_id_n;
  logic              ext_f, ext_f_n, rtr_f, rtr_f_n;
  logic [3:0]        dlc_f, dlc_f_n;
  logic [DATA_W-1:0] data_sr, data_n;

  logic [28:0]       msg_id_n;
  logic              extended_n, rtr_n, fresh_n, ack_n, idle_n, bypass_n;
  logic              start_n, form_n, ovl_n, tx_err_n, sof;
  logic [3:0]        msg_bytes_n;
  logic [DATA_W-1:0] msg_n;

  logic [3:0]        bytes_c;
  logic [CNT_W-1:0]  data_last_c, ctrl_last_c;
  logic [3:0]        dlc_fin_c;
  logic              crc_ok_c;

  // One LFSR step of the CRC-15 over a single bit.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
    crc_step = {c[CRC_W-2:0], 1'b0} ^ (((b ^ c[CRC_W-1]) == 1'b1) ? CRC_POLY : '0);
  endfunction

  // Effective payload length: remote frames carry none, DLC saturates at 8.
  always_comb begin
    bytes_c     = rtr_f ? 4'd0 : ((dlc_f > 4'd8) ? 4'd8 : dlc_f);
    data_last_c = CNT_W'({bytes_c, 3'b000}) - CNT_W'(1);
    ctrl_last_c = ext_f ? CNT_W'(6) : CNT_W'(4);
    dlc_fin_c   = {dlc_f[2:0], rx};
    crc_ok_c    = (crc_rx == crc);
  end

  // Next-state and next-register logic.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    crc_n       = crc;
    crc_rx_n    = crc_rx;
    base_id_n   = base_id;
    ext_id_n    = ext_id;
    ext_f_n     = ext_f;
    rtr_f_n     = rtr_f;
    dlc_f_n     = dlc_f;
    data_n      = data_sr;
    msg_id_n    = msg_id;
    extended_n  = extended;
    rtr_n       = rtr;
    msg_bytes_n = msg_bytes;
    msg_n       = msg;
    fresh_n     = 1'b0;
    start_n     = 1'b0;
    form_n      = 1'b0;
    ovl_n       = 1'b0;
    tx_err_n    = 1'b0;
    sof         = 1'b0;

    if (updated_sample) begin
      cnt_n = cnt + CNT_W'(1);
      if (!stuff_bypass && (stuff_error || bit_error)) begin
        tx_err_n = 1'b1;
        state_n  = WAIT_IDLE;
      end else begin
        case (state)
          IDLE: if (rx) sof = 1'b1;
          ARB_BASE: begin
            crc_n     = crc_step(crc, rx);
            base_id_n = {base_id[BID_W-2:0], rx};
            if (cnt == CNT_W'(BID_W - 1)) state_n = SRR_IDE;
          end
          SRR_IDE: begin
            crc_n = crc_step(crc, rx);
            if (cnt == '0) begin
              rtr_f_n = ~rx;                  // RTR for base frames, SRR otherwise
            end else begin
              ext_f_n = ~rx;                  // dominant IDE means base frame
              state_n = rx ? CTRL : ARB_EXT;
            end
          end
          ARB_EXT: begin
            crc_n    = crc_step(crc, rx);
            ext_id_n = {ext_id[EID_W-2:0], rx};
            if (cnt == CNT_W'(EID_W - 1)) state_n = CTRL;
          end
          CTRL: begin
            // Every control bit shifts through dlc_f; only the last four remain.
            crc_n   = crc_step(crc, rx);
            dlc_f_n = dlc_fin_c;
            if (ext_f && cnt == '0) rtr_f_n = ~rx;
            if (cnt == ctrl_last_c)
              state_n = (rtr_f || dlc_fin_c == 4'd0) ? CRC : DATA;
          end
          DATA: begin
            crc_n  = crc_step(crc, rx);
            data_n = {data_sr[DATA_W-2:0], rx};
            if (cnt == data_last_c) state_n = CRC;
          end
          CRC: begin
            crc_rx_n = {crc_rx[CRC_W-2:0], rx};
            if (cnt == CNT_W'(CRC_W - 1)) state_n = CRC_DELIM;
          end
          CRC_DELIM: begin
            form_n  = rx;
            state_n = rx ? WAIT_IDLE : ACK;
          end
          ACK: state_n = ACK_DELIM;
          ACK_DELIM: begin
            if (!crc_ok_c) begin
              tx_err_n = 1'b1;
              state_n  = WAIT_IDLE;
            end else begin
              form_n  = rx;
              state_n = rx ? WAIT_IDLE : EOF;
            end
          end
          EOF: begin
            if (rx) begin
              form_n  = 1'b1;
              state_n = WAIT_IDLE;
            end else if (cnt == CNT_W'(6)) begin
              msg_id_n    = {base_id, ext_id};
              extended_n  = ext_f;
              rtr_n       = rtr_f;
              msg_bytes_n = bytes_c;
              msg_n       = data_sr;
              fresh_n     = 1'b1;
              state_n     = INTERMISSION;
            end
          end
          INTERMISSION: begin
            if (cnt != CNT_W'(2)) begin
              ovl_n = rx;
              if (rx) state_n = WAIT_IDLE;
            end else if (rx) begin
              sof = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end
          WAIT_IDLE: begin
            if (rx) cnt_n = '0;
            else if (cnt == CNT_W'(10)) state_n = IDLE;
          end
          default: state_n = WAIT_IDLE;
        endcase
      end

      // Start of frame: clear all per-frame state and seed the CRC with SOF.
      if (sof) begin
        state_n   = ARB_BASE;
        crc_n     = crc_step('0, rx);
        crc_rx_n  = '0;
        base_id_n = '0;
        ext_id_n  = '0;
        ext_f_n   = 1'b0;
        rtr_f_n   = 1'b0;
        dlc_f_n   = '0;
        data_n    = '0;
        start_n   = 1'b1;
      end
      if (state_n != state) cnt_n = '0;
    end

    idle_n   = (state_n == IDLE);
    bypass_n = (state_n inside {IDLE, CRC_DELIM, ACK, ACK_DELIM, EOF, INTERMISSION, WAIT_IDLE});
    ack_n    = (state_n == ACK) && crc_ok_c;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= IDLE;
      cnt                <= '0;
      crc                <= '0;
      crc_rx             <= '0;
      base_id            <= '0;
      ext_id             <= '0;
      ext_f              <= 1'b0;
      rtr_f              <= 1'b0;
      dlc_f              <= '0;
      data_sr            <= '0;
      msg_id             <= '0;
      extended           <= 1'b0;
      rtr                <= 1'b0;
      msg_bytes          <= '0;
      msg                <= '0;
      msg_fresh          <= 1'b0;
      fire_an_ack        <= 1'b0;
      bus_idle           <= 1'b1;
      stuff_bypass       <= 1'b1;
      running_start      <= 1'b0;
      FORM_ERROR         <= 1'b0;
      OVERLOAD_ERROR     <= 1'b0;
      transmission_error <= 1'b0;
    end else begin
      state              <= state_n;
      cnt                <= cnt_n;
      crc                <= crc_n;
      crc_rx             <= crc_rx_n;
      base_id            <= base_id_n;
      ext_id             <= ext_id_n;
      ext_f              <= ext_f_n;
      rtr_f              <= rtr_f_n;
      dlc_f              <= dlc_f_n;
      data_sr            <= data_n;
      msg_id             <= msg_id_n;
      extended           <= extended_n;
      rtr                <= rtr_n;
      msg_bytes          <= msg_bytes_n;
      msg                <= msg_n;
      msg_fresh          <= fresh_n;
      fire_an_ack        <= ack_n;
      bus_idle           <= idle_n;
      stuff_bypass       <= bypass_n;
      running_start      <= start_n;
      FORM_ERROR         <= form_n;
      OVERLOAD_ERROR     <= ovl_n;
      transmission_error <= tx_err_n;
    end
  end

endmodule

// File: tb/tb_message_receiver.sv
// Self-checking bench for message_receiver: frames are assembled as bit lists
// from field values, the CRC comes from polynomial long division, and the
// expected pulses/outputs follow from the frame outcome.
module tb_message_receiver;

  localparam int M_OK = 0, M_CRC = 1, M_FORM = 2, M_STUFF = 3, M_BITE = 4, M_OVL = 5;

  logic clk = 1'b0;
  logic rst_n, updated_sample, rx, stuff_error, bit_error;
  logic [28:0] msg_id;
  logic extended, rtr, msg_fresh, fire_an_ack, bus_idle, stuff_bypass;
  logic running_start, FORM_ERROR, OVERLOAD_ERROR, transmission_error;
  logic [3:0]  msg_bytes;
  logic [63:0] msg;

  message_receiver dut (
    .clk(clk), .rst_n(rst_n), .updated_sample(updated_sample), .rx(rx),
    .stuff_error(stuff_error), .bit_error(bit_error), .msg_id(msg_id),
    .extended(extended), .rtr(rtr), .msg_bytes(msg_bytes), .msg(msg),
    .msg_fresh(msg_fresh), .fire_an_ack(fire_an_ack), .bus_idle(bus_idle),
    .stuff_bypass(stuff_bypass), .running_start(running_start),
    .FORM_ERROR(FORM_ERROR), .OVERLOAD_ERROR(OVERLOAD_ERROR),
    .transmission_error(transmission_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_mis = 0;
  int n_fresh = 0, n_tx = 0, n_form = 0, n_ovl = 0, n_start = 0;

  // Pulse counters.
  always @(negedge clk) begin
    if (msg_fresh)          n_fresh = n_fresh + 1;
    if (transmission_error) n_tx    = n_tx + 1;
    if (FORM_ERROR)         n_form  = n_form + 1;
    if (OVERLOAD_ERROR)     n_ovl   = n_ovl + 1;
    if (running_start)      n_start = n_start + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_mis = n_mis + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame under construction and its expected published values.
  bit fb[$];
  int delim_pos, data_pos;
  logic [28:0] f_id;
  logic        f_ext, f_rtr;
  logic [3:0]  f_bytes;
  logic [63:0] f_msg;
  logic [28:0] e_id    = '0;
  logic        e_ext   = 1'b0, e_rtr = 1'b0;
  logic [3:0]  e_bytes = '0;
  logic [63:0] e_msg   = '0;

  // Remainder of (bits * x^15) divided by x^15 + 0x4599.
  function automatic logic [14:0] ref_crc(input int n);
    logic [15:0] rem;
    rem = '0;
    for (int i = 0; i < n + 15; i++) begin
      rem = {rem[14:0], (i < n) ? fb[i] : 1'b0};
      if (rem[15]) rem ^= 16'hC599;
    end
    return rem[14:0];
  endfunction

  task automatic build_frame(input bit ext, input bit [10:0] bid, input bit [17:0] eid,
                             input bit remote, input bit [3:0] dlc, input bit [63:0] data,
                             input bit [14:0] crc_xor, input bit [1:0] rsv);
    int nb;
    logic [14:0] c;
    fb.delete();
    fb.push_back(1'b1);
    for (int i = 10; i >= 0; i--) fb.push_back(bid[i]);
    if (ext) begin
      fb.push_back(rsv[1]);
      fb.push_back(1'b0);
      for (int i = 17; i >= 0; i--) fb.push_back(eid[i]);
      fb.push_back(~remote);
      fb.push_back(rsv[1]);
      fb.push_back(rsv[0]);
    end else begin
      fb.push_back(~remote);
      fb.push_back(1'b1);
      fb.push_back(rsv[0]);
    end
    for (int i = 3; i >= 0; i--) fb.push_back(dlc[i]);
    data_pos = fb.size();
    nb = remote ? 0 : ((dlc > 8) ? 8 : int'(dlc));
    f_msg = '0;
    for (int i = nb * 8 - 1; i >= 0; i--) begin
      fb.push_back(data[i]);
      f_msg[i] = data[i];
    end
    c = ref_crc(fb.size()) ^ crc_xor;
    for (int i = 14; i >= 0; i--) fb.push_back(c[i]);
    delim_pos = fb.size();
    fb.push_back(1'b0);
    fb.push_back(1'b1);
    for (int i = 0; i < 11; i++) fb.push_back(1'b0);
    f_id    = {bid, ext ? eid : 18'd0};
    f_ext   = ext;
    f_rtr   = remote;
    f_bytes = 4'(nb);
  endtask

  task automatic rand_frame(input bit [14:0] crc_xor);
    build_frame(1'($urandom), 11'($urandom), 18'($urandom), $urandom_range(0, 4) == 0,
                4'($urandom), {$urandom, $urandom}, crc_xor, 2'($urandom));
  endtask

  // One strobed bit followed by a few ignored cycles carrying junk on rx.
  task automatic send_bit(input logic b, input logic se, input logic be);
    @(negedge clk);
    rx = b; updated_sample = 1'b1; stuff_error = se; bit_error = be;
    @(negedge clk);
    updated_sample = 1'b0; stuff_error = 1'b0; bit_error = 1'b0; rx = 1'($urandom);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    #1;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_id"},    64'(msg_id),    64'(e_id));
    chk({tag, "_ext"},   64'(extended),  64'(e_ext));
    chk({tag, "_rtr"},   64'(rtr),       64'(e_rtr));
    chk({tag, "_bytes"}, 64'(msg_bytes), 64'(e_bytes));
    chk({tag, "_msg"},   msg,            e_msg);
  endtask

  // Eleven recessive bits since the last dominant one end WAIT_IDLE.
  task automatic recover();
    repeat (5) send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    repeat (10) send_bit(1'b0, 1'b0, 1'b0);
    chk("wait_10_recessive", 64'(bus_idle), 64'd0);
    chk("wait_bypass", 64'(stuff_bypass), 64'd1);
    send_bit(1'b0, 1'b0, 1'b0);
    chk("wait_11_recessive", 64'(bus_idle), 64'd1);
  endtask

  task automatic run_frame(input int mode, input int pos);
    int last, f0, t0, fm0, o0, s0;
    bit good;
    last = fb.size() - 1;
    case (mode)
      M_CRC:            last = delim_pos + 2;
      M_FORM:           begin fb[pos] = 1'b1; last = pos; end
      M_STUFF, M_BITE:  last = pos;
      M_OVL:            begin fb[delim_pos + 10 + pos] = 1'b1; last = delim_pos + 10 + pos; end
      default:          last = fb.size() - 1;
    endcase
    f0 = n_fresh; t0 = n_tx; fm0 = n_form; o0 = n_ovl; s0 = n_start;
    for (int i = 0; i <= last; i++) begin
      send_bit(fb[i], mode == M_STUFF && i == last, mode == M_BITE && i == last);
      if (i == 0) begin
        chk("sof_bypass", 64'(stuff_bypass), 64'd0);
        chk("sof_busy", 64'(bus_idle), 64'd0);
      end
      if (i == delim_pos && last > delim_pos) begin
        chk("ack_request", 64'(fire_an_ack), 64'(mode != M_CRC));
        chk("ack_bypass", 64'(stuff_bypass), 64'd1);
      end
    end
    good = (mode == M_OK) || (mode == M_OVL);
    chk("fresh_pulses", 64'(n_fresh - f0), 64'(good));
    chk("txerr_pulses", 64'(n_tx - t0), 64'(mode == M_CRC || mode == M_STUFF || mode == M_BITE));
    chk("form_pulses", 64'(n_form - fm0), 64'(mode == M_FORM));
    chk("ovl_pulses", 64'(n_ovl - o0), 64'(mode == M_OVL));
    chk("start_pulses", 64'(n_start - s0), 64'd1);
    if (good) begin
      e_id = f_id; e_ext = f_ext; e_rtr = f_rtr; e_bytes = f_bytes; e_msg = f_msg;
    end
    chk_outputs("frame");
    if (mode == M_OK) chk("idle_after_frame", 64'(bus_idle), 64'd1);
    else recover();
  endtask

  // Back-to-back: the third intermission bit of frame A is the SOF of frame B.
  task automatic run_b2b();
    int f0, s0;
    f0 = n_fresh; s0 = n_start;
    rand_frame(15'd0);
    for (int i = 0; i < fb.size() - 1; i++) send_bit(fb[i], 1'b0, 1'b0);
    rand_frame(15'd0);
    for (int i = 0; i < fb.size(); i++) send_bit(fb[i], 1'b0, 1'b0);
    chk("b2b_fresh", 64'(n_fresh - f0), 64'd2);
    chk("b2b_start", 64'(n_start - s0), 64'd2);
    e_id = f_id; e_ext = f_ext; e_rtr = f_rtr; e_bytes = f_bytes; e_msg = f_msg;
    chk_outputs("b2b");
  endtask

  task automatic reset_mid_frame();
    int k, f0, t0, fm0;
    rand_frame(15'd0);
    k = $urandom_range(1, fb.size() - 5);
    f0 = n_fresh; t0 = n_tx; fm0 = n_form;
    for (int i = 0; i < k; i++) send_bit(fb[i], 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    #1;
    chk("rst_mid_fresh", 64'(n_fresh - f0), 64'd0);
    chk("rst_mid_txerr", 64'(n_tx - t0), 64'd0);
    chk("rst_mid_form", 64'(n_form - fm0), 64'd0);
    chk("rst_mid_idle", 64'(bus_idle), 64'd1);
    chk("rst_mid_bypass", 64'(stuff_bypass), 64'd1);
    e_id = '0; e_ext = 1'b0; e_rtr = 1'b0; e_bytes = '0; e_msg = '0;
    chk_outputs("rst_mid");
  endtask

  initial begin
    int mode, pos;
    rst_n = 1'b0; updated_sample = 1'b1; rx = 1'b1; stuff_error = 1'b0; bit_error = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; updated_sample = 1'b0; rx = 1'b0;
    #1;
    chk("rst_idle", 64'(bus_idle), 64'd1);
    chk("rst_bypass", 64'(stuff_bypass), 64'd1);
    chk("rst_ack", 64'(fire_an_ack), 64'd0);
    chk("rst_pulses", 64'(n_fresh + n_tx + n_form + n_ovl + n_start), 64'd0);
    chk_outputs("rst");

    // Base frame, ID 0x333, DLC 0.
    build_frame(1'b0, 11'b01100110011, 18'd0, 1'b0, 4'd0, 64'd0, 15'd0, 2'b11);
    run_frame(M_OK, 0);
    chk("d031_id", 64'(msg_id[28:18]), 64'h333);
    chk("d031_bytes", 64'(msg_bytes), 64'd0);

    // Same frame with a corrupted CRC.
    build_frame(1'b0, 11'b01100110011, 18'd0, 1'b0, 4'd0, 64'd0, 15'h3153, 2'b11);
    run_frame(M_CRC, 0);

    // Full 8-byte base frame.
    build_frame(1'b0, 11'b10001010101, 18'd0, 1'b0, 4'd8, 64'hd3359da81bd963e5, 15'd0, 2'b11);
    run_frame(M_OK, 0);
    chk("d033_msg", msg, 64'hd3359da81bd963e5);
    chk("d033_id", 64'(msg_id[28:18]), 64'h455);

    // Extended frame.
    build_frame(1'b1, 11'b01110101010, 18'b100010101010101010, 1'b0, 4'd8,
                64'hd3359da81bd963e5 ^ 64'hAAAAAAAAAAAAAAAA, 15'd0, 2'b00);
    run_frame(M_OK, 0);
    chk("d034_ext", 64'(extended), 64'd1);
    chk("d034_id", 64'(msg_id), 64'({11'b01110101010, 18'b100010101010101010}));

    // Form errors at the CRC and ACK delimiters.
    rand_frame(15'd0);
    run_frame(M_FORM, delim_pos);
    rand_frame(15'd0);
    run_frame(M_FORM, delim_pos + 2);

    // Stuff error in DATA, then a clean frame.
    build_frame(1'b0, 11'b10001010101, 18'd0, 1'b0, 4'd8, 64'hd3359da81bd963e5, 15'd0, 2'b11);
    run_frame(M_STUFF, data_pos + 10);
    rand_frame(15'd0);
    run_frame(M_OK, 0);

    // Overload in either of the first two intermission bits.
    rand_frame(15'd0);
    run_frame(M_OVL, 0);
    rand_frame(15'd0);
    run_frame(M_OVL, 1);

    run_b2b();
    reset_mid_frame();

    for (int n = 0; n < 30; n++) begin
      mode = $urandom_range(0, 5);
      rand_frame(mode == M_CRC ? 15'($urandom_range(1, 32767)) : 15'd0);
      case (mode)
        M_FORM: begin
          pos = $urandom_range(0, 8);
          pos = delim_pos + ((pos == 0) ? 0 : pos + 1);
        end
        M_STUFF, M_BITE: pos = $urandom_range(1, delim_pos - 1);
        M_OVL:           pos = $urandom_range(0, 1);
        default:         pos = 0;
      endcase
      run_frame(mode, pos);
      if (n % 10 == 9) reset_mid_frame();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
